// File: rtl/pxie_c2h_tx_pkg.sv
// Shared constants, FSM encoding and beat builders for the PXIe card-to-host reply path.
package pxie_c2h_tx_pkg;

    localparam logic [15:0] PXIE_SYNC      = 16'hEB9C;
    localparam logic [15:0] C2H_REPLY_CODE = 16'h2010;

    localparam int unsigned HDR_SYNC_LSB  = 112;
    localparam int unsigned HDR_LEN_LSB   = 96;
    localparam int unsigned HDR_ADDR_LSB  = 80;
    localparam int unsigned HDR_CODE_LSB  = 0;
    localparam int unsigned TAIL_CSUM_LSB = 0;

    typedef enum logic [2:0] {
        StIdle,
        StHead,
        StRead,
        StTail,
        StWait
    } c2h_state_e;

    function automatic logic [127:0] make_header(input logic [15:0] len, input logic [15:0] addr);
        logic [127:0] beat;
        beat                        = '0;
        beat[HDR_SYNC_LSB +: 16]    = PXIE_SYNC;
        beat[HDR_LEN_LSB +: 16]     = len;
        beat[HDR_ADDR_LSB +: 16]    = addr;
        beat[HDR_CODE_LSB +: 16]    = C2H_REPLY_CODE;
        return beat;
    endfunction

    function automatic logic [127:0] make_tail(input logic [15:0] len, input logic [31:0] csum);
        logic [127:0] beat;
        beat                        = '0;
        beat[HDR_SYNC_LSB +: 16]    = PXIE_SYNC;
        beat[HDR_LEN_LSB +: 16]     = len;
        beat[TAIL_CSUM_LSB +: 32]   = csum;
        return beat;
    endfunction

endpackage

// File: rtl/pxie_c2h_tx_if.sv
// Request, config-RAM read, output stream and status signals of the C2H responder.
interface pxie_c2h_tx_if #(
    parameter int unsigned RAM_AW = 16,
    parameter int unsigned RAM_DW = 128
);
    logic              I_C2h_En;
    logic [15:0]       I_C2h_Addr;
    logic [15:0]       I_C2h_Len;
    logic              O_Ram_Rd_En;
    logic [RAM_AW-1:0] O_Ram_Addr;
    logic [RAM_DW-1:0] I_Ram_Rd_Data;
    logic [RAM_DW-1:0] O_Tx_Data;
    logic              O_Tx_Vld;
    logic              I_Tx_Rdy;
    logic              O_Tx_Last;
    logic              O_Busy;
    logic              O_Done;
    logic              O_Drop;

    modport master (
        input  I_C2h_En, I_C2h_Addr, I_C2h_Len, I_Ram_Rd_Data, I_Tx_Rdy,
        output O_Ram_Rd_En, O_Ram_Addr, O_Tx_Data, O_Tx_Vld, O_Tx_Last, O_Busy, O_Done, O_Drop
    );

    modport slave (
        output I_C2h_En, I_C2h_Addr, I_C2h_Len, I_Ram_Rd_Data, I_Tx_Rdy,
        input  O_Ram_Rd_En, O_Ram_Addr, O_Tx_Data, O_Tx_Vld, O_Tx_Last, O_Busy, O_Done, O_Drop
    );

endinterface

// File: rtl/pxie_c2h_tx_skid_fifo.sv
// Small synchronous output FIFO; push is honoured on a full FIFO when a pop frees a slot.
module pxie_c2h_tx_skid_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 129,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             I_PXIE_CLK,
    input  logic             I_Rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam logic [AW:0] DEP_L = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEP_L);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Zero when empty so the stream data reads 0 straight out of reset.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge I_PXIE_CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/pxie_c2h_tx.sv
// Card-to-host responder: header, config-RAM data words and checksummed tail per accepted request.
module pxie_c2h_tx
    import pxie_c2h_tx_pkg::*;
#(
    parameter int unsigned RAM_AW   = 16,
    parameter int unsigned RAM_DW   = 128,
    parameter int unsigned SKID_DEP = 4
) (
    input logic           I_PXIE_CLK,
    input logic           I_Rst_n,
    pxie_c2h_tx_if.master c2h
);
    localparam int unsigned CNT_W = $clog2(SKID_DEP) + 1;
    localparam logic [CNT_W:0] DEP_L = (CNT_W + 1)'(SKID_DEP);

    c2h_state_e        state_q, state_d;
    logic [15:0]       req_addr_q, req_addr_d;
    logic [15:0]       len_q, len_d;
    logic [RAM_AW-1:0] rd_addr_q, rd_addr_d;
    logic [16:0]       rd_cnt_q, rd_cnt_d;
    logic [16:0]       wr_cnt_q, wr_cnt_d;
    logic              inflight_q;
    logic [31:0]       csum_q, csum_d;

    logic              push, pop, can_push, fifo_full, fifo_empty;
    logic [RAM_DW:0]   push_data, fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    used;
    logic              credit_ok, rd_pending, rd_en, done, busy;

    assign pop        = !fifo_empty && c2h.I_Tx_Rdy;
    assign can_push   = !fifo_full || pop;
    assign busy       = (state_q != StIdle);
    // Slots already occupied plus a word still on its way back from the RAM.
    assign used       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok  = (used < DEP_L);
    assign rd_pending = (rd_cnt_q < {1'b0, len_q});

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        len_d      = len_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        csum_d     = csum_q;
        push       = 1'b0;
        push_data  = '0;
        rd_en      = 1'b0;
        done       = 1'b0;

        if (inflight_q) begin
            push      = 1'b1;
            push_data = {1'b0, c2h.I_Ram_Rd_Data};
            csum_d    = csum_q ^ c2h.I_Ram_Rd_Data[31:0];
            wr_cnt_d  = wr_cnt_q + 17'd1;
        end

        // Reads start alongside the header so the first data word follows it without a gap.
        if ((state_q == StHead || state_q == StRead) && rd_pending && credit_ok) begin
            rd_en     = 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            rd_cnt_d  = rd_cnt_q + 17'd1;
        end

        case (state_q)
            StIdle: begin
                if (c2h.I_C2h_En) begin
                    req_addr_d = c2h.I_C2h_Addr;
                    len_d      = c2h.I_C2h_Len;
                    rd_addr_d  = RAM_AW'(c2h.I_C2h_Addr);
                    rd_cnt_d   = '0;
                    wr_cnt_d   = '0;
                    csum_d     = '0;
                    state_d    = StHead;
                end
            end
            StHead: begin
                if (can_push) begin
                    push      = 1'b1;
                    push_data = {1'b0, make_header(len_q, req_addr_q)};
                    state_d   = (len_q == '0) ? StTail : StRead;
                end
            end
            StRead: begin
                if (inflight_q && (wr_cnt_q + 17'd1 == {1'b0, len_q})) state_d = StTail;
            end
            StTail: begin
                if (can_push) begin
                    push      = 1'b1;
                    push_data = {1'b1, make_tail(len_q, csum_q)};
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (pop && fifo_dout[RAM_DW]) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge I_PXIE_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            state_q    <= StIdle;
            req_addr_q <= '0;
            len_q      <= '0;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            inflight_q <= 1'b0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            len_q      <= len_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            inflight_q <= rd_en;
            csum_q     <= csum_d;
        end
    end

    pxie_c2h_tx_skid_fifo #(
        .DEPTH (SKID_DEP),
        .WIDTH (RAM_DW + 1)
    ) u_skid_fifo (
        .I_PXIE_CLK (I_PXIE_CLK),
        .I_Rst_n    (I_Rst_n),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .pop_data   (fifo_dout),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign c2h.O_Ram_Rd_En = rd_en;
    assign c2h.O_Ram_Addr  = rd_addr_q;
    assign c2h.O_Tx_Data   = fifo_dout[RAM_DW-1:0];
    assign c2h.O_Tx_Last   = fifo_dout[RAM_DW];
    assign c2h.O_Tx_Vld    = !fifo_empty;
    assign c2h.O_Busy      = busy;
    assign c2h.O_Done      = done;
    assign c2h.O_Drop      = c2h.I_C2h_En && busy;

endmodule
